sipo_deframer: RTL and testbench
================================

Name: sipo_deframer

Overview:
- Downstream consumer of the 4-bit parallel-in/serial-out shifter's serial output.
- Reassembles framed serial bits, MSB first, into a parallel word.
- Optionally checks an even-parity bit.
- Presents each word on a valid/ready output register, with sticky overrun and framing-error flags.
- Sits between the PISO serial link and any parallel sink; single clock domain.

Parameters:
- WIDTH, 4, data bits per frame (2..16).
- PARITY, 0, 1 = one even-parity bit follows the data bits; 0 = none.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  asynchronous active-high reset.
- sin  in  1  serial data bit.
- sin_en  in  1  sin is valid this cycle; no bit is consumed when low.
- frame_start  in  1  qualifies with sin_en: this bit is the first (MSB) bit of a new frame.
- dout  out  WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  sink accepts dout this cycle.
- perr  out  1  parity error for the word in dout (0 when PARITY=0).
- busy  out  1  a frame is being shifted in.
- overrun  out  1  sticky: a completed frame was dropped.
- frame_err  out  1  sticky: a frame was aborted by an early frame_start.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (async, res=1): state IDLE; shift register, bit counter, dout, dout_valid, perr, busy, overrun and frame_err all 0. Reset mid-frame discards the partial frame.
- FSM states:
  - IDLE: a bit is captured only when sin_en=1 && frame_start=1. That bit becomes the MSB, the counter is set to 1, and the FSM moves to SHIFT. Bits with sin_en=1 && frame_start=0 are ignored.
  - SHIFT:
    - sin_en=0: hold all state (stall).
    - sin_en=1 && frame_start=0: shift sin in at the LSB and increment the counter.
    - sin_en=1 && frame_start=1: abort the frame, set frame_err, and restart with this bit as the MSB (counter=1, stay in SHIFT).
  - Frame length N = WIDTH + PARITY bits. On the edge consuming bit N, the frame completes and the FSM returns to IDLE.
- busy = (state == SHIFT), registered.
- Parity: perr = XOR of the WIDTH data bits and the parity bit (even parity; 1 = error).
- Completion at edge E:
  - If dout_valid=0, or dout_ready=1 at E: load dout and perr, and set dout_valid=1. Visible the cycle after E, so latency is 1 edge after the last bit.
  - If dout_valid=1 && dout_ready=0: drop the new word, keep dout/perr unchanged, and set overrun.
- Handshake:
  - dout_valid && dout_ready with no completion on that edge: dout_valid goes to 0; dout and perr keep their last values.
  - dout_valid is never deasserted without dout_ready.
- Sticky flags:
  - clr_err=1 clears overrun and frame_err.
  - If a set event and clr_err occur on the same edge, set wins.
- A frame_start on the final bit position is an abort-and-restart, not a completion.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=4, PARITY=0: reset, then frame_start+sin_en on bits 1,0,0,1 over 4 consecutive edges → after the 4th edge dout=4'b1001, dout_valid=1, busy=0; dout_ready=1 for one cycle → dout_valid=0.
- Back-to-back with sink stalled: receive 1001 with dout_ready=0, then receive 1010 → overrun=1, dout stays 4'b1001. Then clr_err=1 → overrun=0. Repeat 1010 with dout_ready=1 held on the completion edge → dout=4'b1010, overrun stays 0.
- PARITY=1, WIDTH=4:
  - Frame 1,0,1,0 + parity 0 → dout=4'b1010, perr=0.
  - Frame 1,1,1,0 + parity 0 → dout=4'b1110, perr=1.
- Stall and abort:
  - Send 1,0 then sin_en=0 for 3 cycles, then 0,1 → dout=4'b1001 (stall is transparent).
  - Send 1,1 then frame_start with bits 0,1,1,0 → frame_err=1, dout=4'b0110.
- Reset mid-frame: after 2 bits of a frame, pulse res asynchronously (between edges) → all outputs 0 immediately. A following complete frame 0011 → dout=4'b0011, frame_err=0.
- Idle noise: sin_en=1 with frame_start=0 for 5 cycles in IDLE → busy=0, dout_valid=0, no flag changes.

Source files
------------

// File: rtl/sipo_deframer_if.sv
// -----------------------------------------------------------------------------
// sipo_deframer_if
//   Bundles the serial input stream, the valid/ready parallel output and the
//   status/error flags of the SIPO deframer.
//
//   master : the side that feeds serial bits, consumes words and clears flags
//            (link driver + parallel sink).
//   slave  : the deframer itself.
//
//   Signals
//     sin, sin_en, frame_start  serial bit, bit qualifier, first-bit marker
//     dout, dout_valid          assembled word and its valid flag
//     dout_ready                sink accepts dout this cycle
//     perr                      parity error for the word in dout
//     busy                      a frame is being shifted in
//     overrun, frame_err        sticky error flags
//     clr_err                   synchronous clear of the sticky flags
// -----------------------------------------------------------------------------
interface sipo_deframer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_en;
  logic             frame_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             perr;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output sin, sin_en, frame_start, dout_ready, clr_err,
    input  dout, dout_valid, perr, busy, overrun, frame_err
  );

  modport slave (
    input  sin, sin_en, frame_start, dout_ready, clr_err,
    output dout, dout_valid, perr, busy, overrun, frame_err
  );
endinterface

// File: rtl/sipo_deframer.sv
// -----------------------------------------------------------------------------
// sipo_deframer
//   Reassembles MSB-first framed serial bits into a WIDTH-bit word, optionally
//   followed by one even-parity bit, and presents each word on a registered
//   valid/ready output. Sticky flags report dropped words (overrun) and frames
//   aborted by an early frame_start (frame_err).
//
//   Parameters
//     WIDTH   data bits per frame (2..16)
//     PARITY  1 = one even-parity bit follows the data bits, 0 = none
//
//   Ports
//     clk  rising-edge clock
//     res  asynchronous active-high reset
//     bus  sipo_deframer_if.slave (serial input, word output, flags)
//
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
// -----------------------------------------------------------------------------
module sipo_deframer #(
  parameter int WIDTH  = 4,
  parameter int PARITY = 0
) (
  input  logic           clk,
  input  logic           res,
  sipo_deframer_if.slave bus
);

  // Frame length and supporting widths.
  localparam int N  = WIDTH + PARITY;
  localparam int SW = N - 1;            // bits held before the final bit arrives
  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [SW-1:0]    shreg_q,     shreg_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] dout_q,      dout_d;
  logic             valid_q,     valid_d;
  logic             perr_q,      perr_d;
  logic             busy_q,      busy_d;
  logic             overrun_q,   overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             complete;
  logic             abort;
  logic             overrun_set;
  logic [N-1:0]     frame_word;

  // The final bit is never stored: it is merged with the held bits on the
  // completing edge, so the word is loaded straight into dout.
  assign frame_word = {shreg_q, bus.sin};

  // ---------------------------------------------------------------------------
  // Frame assembly FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    abort    = 1'b0;

    case (state_q)
      IDLE: begin
        // Bits without frame_start are noise between frames and are ignored.
        if (bus.sin_en && bus.frame_start) begin
          shreg_d = SW'(bus.sin);
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.sin_en) begin
          if (bus.frame_start) begin
            // Early frame_start, including one on the last bit position:
            // abandon the partial frame and restart with this bit as MSB.
            abort   = 1'b1;
            shreg_d = SW'(bus.sin);
            cnt_d   = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            shreg_d = (shreg_q << 1) | SW'(bus.sin);
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register, handshake and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    dout_d      = dout_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    overrun_set = 1'b0;

    if (complete) begin
      // A word may replace the held one only if the sink takes the old word
      // on this same edge; otherwise the new word is the one that is lost.
      if (!valid_q || bus.dout_ready) begin
        dout_d  = frame_word[N-1 -: WIDTH];
        perr_d  = (PARITY != 0) ? ^frame_word : 1'b0;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear when both happen on the same edge.
    overrun_d   = overrun_set | (overrun_q   & ~bus.clr_err);
    frame_err_d = abort       | (frame_err_q & ~bus.clr_err);
    busy_d      = (state_d == SHIFT);
  end

  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.perr       = perr_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deframer
//   Two deframers, both WIDTH=4: u_dut0 without parity, u_dut1 with parity.
//   A frame-level model (bit count + accumulated value) predicts every output
//   and is compared against both DUTs on each falling edge; directed checks
//   with hand-computed constants pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_sipo_deframer;

  logic clk;
  logic res;

  sipo_deframer_if #(.WIDTH(4)) if0 ();
  sipo_deframer_if #(.WIDTH(4)) if1 ();

  sipo_deframer #(.WIDTH(4), .PARITY(0)) u_dut0 (.clk(clk), .res(res), .bus(if0));
  sipo_deframer #(.WIDTH(4), .PARITY(1)) u_dut1 (.clk(clk), .res(res), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int         nb;     // bits received in the current frame (0 = idle)
    int         acc;    // frame bits as a binary number, MSB first
    logic [3:0] dout;
    logic       valid;
    logic       perr;
    logic       ovr;
    logic       ferr;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_next(input model_t s, input int n, input int par,
                                        input logic en, input logic fs, input logic b,
                                        input logic rdy, input logic clr);
    model_t     r     = s;
    logic       done  = 1'b0;
    logic       set_o = 1'b0;
    logic       set_f = 1'b0;
    logic [3:0] w     = '0;
    logic       p     = 1'b0;
    if (en) begin
      if (fs) begin
        if (s.nb > 0) set_f = 1'b1;
        r.acc = int'(b);
        r.nb  = 1;
      end else if (s.nb > 0) begin
        r.acc = r.acc * 2 + int'(b);
        r.nb  = r.nb + 1;
      end
    end
    if (r.nb == n) begin
      done = 1'b1;
      w    = 4'(r.acc >> par);
      p    = (par != 0) && ($countones(r.acc) % 2 == 1);
      r.nb = 0;
    end
    if (done && (!s.valid || rdy)) begin
      r.dout  = w;
      r.perr  = p;
      r.valid = 1'b1;
    end else if (done) begin
      set_o = 1'b1;
    end else if (s.valid && rdy) begin
      r.valid = 1'b0;
    end
    r.ovr  = set_o | (s.ovr  & ~clr);
    r.ferr = set_f | (s.ferr & ~clr);
    return r;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= model_next(m0, 4, 0, if0.sin_en, if0.frame_start, if0.sin, if0.dout_ready, if0.clr_err);
      m1 <= model_next(m1, 5, 1, if1.sin_en, if1.frame_start, if1.sin, if1.dout_ready, if1.clr_err);
    end
  end

  task automatic cmp(input string tag, input model_t s, input logic [3:0] d, input logic v,
                     input logic p, input logic b, input logic o, input logic f);
    check({tag, "_dout"},      32'(d), 32'(s.dout));
    check({tag, "_valid"},     32'(v), 32'(s.valid));
    check({tag, "_perr"},      32'(p), 32'(s.perr));
    check({tag, "_busy"},      32'(b), 32'(s.nb != 0));
    check({tag, "_overrun"},   32'(o), 32'(s.ovr));
    check({tag, "_frame_err"}, 32'(f), 32'(s.ferr));
  endtask

  always @(negedge clk) begin
    cmp("m0", m0, if0.dout, if0.dout_valid, if0.perr, if0.busy, if0.overrun, if0.frame_err);
    cmp("m1", m1, if1.dout, if1.dout_valid, if1.perr, if1.busy, if1.overrun, if1.frame_err);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge only
  // ---------------------------------------------------------------------------
  task automatic drive(input int idx, input logic en, input logic fs, input logic b,
                       input logic rdy, input logic clr);
    @(negedge clk);
    if0.sin_en = 1'b0; if0.frame_start = 1'b0; if0.sin = 1'b0; if0.dout_ready = 1'b0; if0.clr_err = 1'b0;
    if1.sin_en = 1'b0; if1.frame_start = 1'b0; if1.sin = 1'b0; if1.dout_ready = 1'b0; if1.clr_err = 1'b0;
    if (idx == 0) begin
      if0.sin_en = en; if0.frame_start = fs; if0.sin = b; if0.dout_ready = rdy; if0.clr_err = clr;
    end else begin
      if1.sin_en = en; if1.frame_start = fs; if1.sin = b; if1.dout_ready = rdy; if1.clr_err = clr;
    end
  endtask

  // Sends n bits MSB first; dout_ready is raised only with the last bit.
  task automatic frame(input int idx, input logic [15:0] bits, input int n, input logic rdy_last);
    for (int i = 0; i < n; i++)
      drive(idx, 1'b1, (i == 0), bits[n-1-i], (i == n - 1) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic settle();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic consume(input int idx);
    drive(idx, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    res = 1'b1;
    if0.sin_en = 1'b0; if0.frame_start = 1'b0; if0.sin = 1'b0; if0.dout_ready = 1'b0; if0.clr_err = 1'b0;
    if1.sin_en = 1'b0; if1.frame_start = 1'b0; if1.sin = 1'b0; if1.dout_ready = 1'b0; if1.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    settle();
    check("rst_dout",  32'(if0.dout),       32'h0);
    check("rst_valid", 32'(if0.dout_valid), 32'h0);
    check("rst_busy",  32'(if0.busy),       32'h0);
    check("rst_ovr",   32'(if0.overrun),    32'h0);

    // Basic frame 1001 and a single-cycle consume.
    frame(0, 16'b1001, 4, 1'b0);
    settle();
    check("t1_dout",       32'(if0.dout),       32'h9);
    check("t1_valid",      32'(if0.dout_valid), 32'h1);
    check("t1_busy",       32'(if0.busy),       32'h0);
    check("t1_model_dout", 32'(m0.dout),        32'h9);
    consume(0);
    settle();
    check("t1_consumed", 32'(if0.dout_valid), 32'h0);

    // Overrun with stalled sink, clear, then completion with ready held.
    frame(0, 16'b1001, 4, 1'b0);
    frame(0, 16'b1010, 4, 1'b0);
    settle();
    check("t2_ovr",       32'(if0.overrun), 32'h1);
    check("t2_dout_kept", 32'(if0.dout),    32'h9);
    check("t2_model_ovr", 32'(m0.ovr),      32'h1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check("t2_ovr_clr", 32'(if0.overrun), 32'h0);
    frame(0, 16'b1010, 4, 1'b1);
    settle();
    check("t2_dout_new",  32'(if0.dout),       32'hA);
    check("t2_ovr_stays", 32'(if0.overrun),    32'h0);
    check("t2_valid",     32'(if0.dout_valid), 32'h1);
    consume(0);

    // Parity instance.
    frame(1, 16'b10100, 5, 1'b0);
    settle();
    check("t3_dout_a",  32'(if1.dout), 32'hA);
    check("t3_perr_a",  32'(if1.perr), 32'h0);
    consume(1);
    frame(1, 16'b11100, 5, 1'b0);
    settle();
    check("t3_dout_b",       32'(if1.dout), 32'hE);
    check("t3_perr_b",       32'(if1.perr), 32'h1);
    check("t3_model_perr_b", 32'(m1.perr),  32'h1);
    consume(1);

    // Stall inside a frame is transparent.
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) settle();
    check("t4_busy_stall", 32'(if0.busy), 32'h1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("t4_dout", 32'(if0.dout), 32'h9);
    consume(0);

    // frame_start on the last bit position restarts instead of completing.
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(0, 16'b1000, 4, 1'b0);
    settle();
    check("t5_ferr", 32'(if0.frame_err), 32'h1);
    check("t5_dout", 32'(if0.dout),      32'h8);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check("t5_ferr_clr", 32'(if0.frame_err), 32'h0);

    // Abort after two bits.
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(0, 16'b0110, 4, 1'b0);
    settle();
    check("t6_ferr", 32'(if0.frame_err), 32'h1);
    check("t6_dout", 32'(if0.dout),      32'h6);
    consume(0);

    // Asynchronous reset in the middle of a frame.
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("t7_busy_pre", 32'(if0.busy), 32'h1);
    #2 res = 1'b1;
    #1;
    check("t7_dout",  32'(if0.dout),       32'h0);
    check("t7_valid", 32'(if0.dout_valid), 32'h0);
    check("t7_busy",  32'(if0.busy),       32'h0);
    check("t7_ferr",  32'(if0.frame_err),  32'h0);
    #1 res = 1'b0;
    frame(0, 16'b0011, 4, 1'b0);
    settle();
    check("t7_dout_after", 32'(if0.dout),      32'h3);
    check("t7_ferr_after", 32'(if0.frame_err), 32'h0);
    consume(0);

    // Noise in IDLE is ignored.
    repeat (5) drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("t8_busy",  32'(if0.busy),       32'h0);
    check("t8_valid", 32'(if0.dout_valid), 32'h0);
    check("t8_ovr",   32'(if0.overrun),    32'h0);
    check("t8_ferr",  32'(if0.frame_err),  32'h0);
    check("t8_dout",  32'(if0.dout),       32'h3);

    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
